pow_n_pipe_hs: RTL and testbench

Parametrised pipelined power unit: for each accepted operand `n` it computes `n^2 … n^N`, one multiply per stage. It is the successor to the fixed fifth-power pipeline and adds:
- generic depth `N`
- a valid/ready handshake with backpressure from the final stage
- per-power sticky overflow flags
- optional saturating arithmetic

It sits between an operand producer and a consumer that samples the per-power taps.

---
 rtl/pow_n_pipe_hs_if.sv | 24 ++
 rtl/pow_n_pipe_hs.sv | 81 ++++++++
 tb/tb_pow_n_pipe_hs.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pow_n_pipe_hs_if.sv
// Operand/result handshake bundle for pow_n_pipe_hs.
// master: operand producer + power-N consumer; slave: the pipeline itself.
interface pow_n_pipe_hs_if #(
    parameter int w = 8,
    parameter int N = 5
);
    logic                 n_vld;
    logic [w-1:0]         n;
    logic                 n_rdy;
    logic                 res_rdy;
    logic [N-2:0]         res_vld;
    logic [w*(N-1)-1:0]   res;
    logic [N-2:0]         res_ovf;

    modport master (
        output n_vld, n, res_rdy,
        input  n_rdy, res_vld, res, res_ovf
    );

    modport slave (
        input  n_vld, n, res_rdy,
        output n_rdy, res_vld, res, res_ovf
    );
endinterface

// File: rtl/pow_n_pipe_hs.sv
// pow_n_pipe_hs: pipelined power unit computing n^2 .. n^N, one multiply per
// stage, with a single global stall driven by the power-N consumer.
// Optional macro POW_N_PIPE_SATURATE_EN: once a stage overflows, its product
// and every later product of that operand read all-ones instead of wrapping.
module pow_n_pipe_hs #(
    parameter int w = 8,
    parameter int N = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    pow_n_pipe_hs_if.slave       bus
);
    localparam int W2 = 2 * w;

    // Per-stage state. The last stage never feeds a multiply, so it keeps
    // no operand copy.
    logic           vld_reg [1:N];
    logic [w-1:0]   n_reg   [1:N-1];
    logic [w-1:0]   p_reg   [1:N];
    logic           o_reg   [1:N];

    logic [w-1:0]   p_next  [2:N];
    logic           o_next  [2:N];

    logic           adv;

    // The whole pipe moves together unless the power-N result is stuck.
    assign adv       = clk_en & (bus.res_rdy | ~vld_reg[N]);
    assign bus.n_rdy = adv;

    genvar gi;
    generate
        for (gi = 2; gi <= N; gi++) begin : g_stage
            logic [W2-1:0] q;

            // Full-width product so the overflow check sees every high bit.
            assign q = W2'(p_reg[gi-1]) * W2'(n_reg[gi-1]);
            assign o_next[gi] = o_reg[gi-1] | (|q[W2-1:w]);
`ifdef POW_N_PIPE_SATURATE_EN
            assign p_next[gi] = o_next[gi] ? {w{1'b1}} : q[w-1:0];
`else
            assign p_next[gi] = q[w-1:0];
`endif
        end

        for (gi = 2; gi <= N; gi++) begin : g_tap
            assign bus.res_vld[gi-2]           = vld_reg[gi];
            assign bus.res[(gi-2)*w +: w]      = p_reg[gi];
            assign bus.res_ovf[gi-2]           = o_reg[gi];
        end
    endgenerate

    // Stage registers: reset clears everything, otherwise shift on adv.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= N; s++) begin
                vld_reg[s] <= 1'b0;
                p_reg[s]   <= '0;
                o_reg[s]   <= 1'b0;
            end
            for (int s = 1; s < N; s++) begin
                n_reg[s] <= '0;
            end
        end else if (adv) begin
            // n_rdy equals adv here, so acceptance reduces to n_vld.
            vld_reg[1] <= bus.n_vld;
            n_reg[1]   <= bus.n;
            p_reg[1]   <= bus.n;
            o_reg[1]   <= 1'b0;
            for (int s = 2; s <= N; s++) begin
                vld_reg[s] <= vld_reg[s-1];
                p_reg[s]   <= p_next[s];
                o_reg[s]   <= o_next[s];
            end
            for (int s = 2; s < N; s++) begin
                n_reg[s] <= n_reg[s-1];
            end
        end
    end
endmodule

// File: tb/tb_pow_n_pipe_hs.sv
// Self-checking bench for pow_n_pipe_hs (w=8, N=5): directed scenarios then
// randomized traffic, compared against a history/scoreboard reference model.
module tb_pow_n_pipe_hs;
    localparam int W = 8;
    localparam int NP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;

    pow_n_pipe_hs_if #(.w(W), .N(NP)) bus();

    pow_n_pipe_hs #(.w(W), .N(NP)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        bit         v;
        logic [7:0] n;
    } ent_t;

    // hist[k-1] is the slot now sitting at stage k (newest first).
    ent_t       hist[$];
    logic [7:0] sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // True n^k: overflow when it exceeds 8 bits; value wraps or saturates.
    task automatic pow_ref(input logic [7:0] b, input int k, output logic [7:0] val, output bit ovf);
        longint t = 1;
        int     m = 1;
        ovf = 1'b0;
        for (int i = 0; i < k; i++) begin
            t = t * b;
            if (t > 255) begin
                ovf = 1'b1;
                t   = 256;
            end
            m = (m * b) % 256;
        end
`ifdef POW_N_PIPE_SATURATE_EN
        val = ovf ? 8'hFF : m[7:0];
`else
        val = m[7:0];
`endif
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0;
        e.n = 8'd0;
        hist.delete();
        sb.delete();
        for (int i = 0; i < NP; i++) hist.push_back(e);
    endtask

    // One clock: inputs were set at the preceding negedge.
    task automatic cycle(output bit acc);
        bit         adv, vldn, xfer, eo;
        logic [7:0] ev, got;
        ent_t       e;
        #1;
        vldn = hist[NP-1].v;
        adv  = clk_en && (bus.res_rdy || !vldn);
        check_val("n_rdy", bus.n_rdy, adv);
        xfer = !rst && clk_en && vldn && bus.res_rdy;
        acc  = !rst && adv && bus.n_vld;
        if (xfer) begin
            got = bus.res[(NP-2)*W +: W];
            if (sb.size() > 0) begin
                e.n = sb.pop_front();
                pow_ref(e.n, NP, ev, eo);
                $display("xfer n=%0d pow%0d=%0d ovf=%0b", e.n, NP, got, bus.res_ovf[NP-2]);
                check_val("xfer_res", got, ev);
                check_val("xfer_ovf", bus.res_ovf[NP-2], eo);
            end else begin
                check_val("xfer_spurious", bus.res_vld[NP-2], 0);
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (adv) begin
            if (bus.n_vld) sb.push_back(bus.n);
            e.v = bus.n_vld;
            e.n = bus.n;
            hist.push_front(e);
            void'(hist.pop_back());
        end
        #1;
        for (int k = 2; k <= NP; k++) begin
            pow_ref(hist[k-1].n, k, ev, eo);
            check_val($sformatf("vld%0d", k), bus.res_vld[k-2], hist[k-1].v);
            check_val($sformatf("res%0d", k), bus.res[(k-2)*W +: W], ev);
            check_val($sformatf("ovf%0d", k), bus.res_ovf[k-2], eo);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit en, input bit v, input logic [7:0] nv, input bit rr);
        rst         = r;
        clk_en      = en;
        bus.n_vld   = v;
        bus.n       = nv;
        bus.res_rdy = rr;
    endtask

    // Single operand followed by idle cycles so it drains fully.
    task automatic single(input logic [7:0] nv);
        bit acc;
        drive(0, 1, 1, nv, 1);
        cycle(acc);
        check_val("single_acc", acc, 1);
        for (int i = 0; i < NP + 1; i++) begin
            drive(0, 1, 0, 8'd0, 1);
            cycle(acc);
        end
    endtask

    initial begin
        bit acc;
        int idx;
        model_reset();
        drive(1, 0, 0, 8'd0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cycle(acc);
        cycle(acc);

        // Basic, overflow, wrap-hides-overflow, edge operands.
        single(8'd3);
        single(8'd4);
        single(8'd16);
        single(8'd0);
        single(8'd1);
        single(8'd255);

        // Stream 1..8 with a 3-cycle consumer hold once power-N is valid.
        idx = 1;
        for (int c = 0; c < 24; c++) begin
            drive(0, 1, idx <= 8, 8'(idx), !(c >= 5 && c < 8));
            cycle(acc);
            if (acc) idx++;
        end
        check_val("stream_all_in", idx, 9);

        // clk_en low for 2 cycles in the middle of a stream.
        for (int c = 0; c < 10; c++) begin
            drive(0, !(c == 4 || c == 5), 1, 8'(c + 2), 1);
            cycle(acc);
        end

        // Reset with operands in flight, then idle: nothing stale may emerge.
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 1, 8'(c + 3), 1);
            cycle(acc);
        end
        drive(1, 1, 1, 8'd7, 1);
        cycle(acc);
        for (int c = 0; c < NP + 2; c++) begin
            drive(0, 1, 0, 8'd0, 1);
            cycle(acc);
        end

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6)),
                  $urandom_range(0, 3) != 0);
            cycle(acc);
        end

        // Drain.
        for (int c = 0; c < NP + 2; c++) begin
            drive(0, 1, 0, 8'd0, 1);
            cycle(acc);
        end
        check_val("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
